// File: rtl/alu_issue_stage.sv
// ID/EX issue stage ahead of the ALU: forwarding from EX/MEM/WB, load-use bubbles, registered operands.
// Optional build macro ISSUE_PERF_COUNTERS_EN adds perf_issued/perf_stalls counters.
module alu_issue_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic                  id_use_imm,
    input  logic [3:0]            id_alu_control,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  flush,
    input  logic                  ex_ready,
    input  logic [XLEN-1:0]       ex_fwd_data,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [XLEN-1:0]       mem_data,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_in1,
    output logic [XLEN-1:0]       ex_in2,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [3:0]            ex_alu_control,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write
`ifdef ISSUE_PERF_COUNTERS_EN
    ,
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_stalls
`endif
);

    logic                  valid_q;
    logic [XLEN-1:0]       in1_q, in2_q, store_q;
    logic [XLEN-1:0]       in1_d, in2_d, store_d, rs2_fwd;
    logic [3:0]            alu_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  rw_q, mr_q, mw_q;
    logic                  advance, load_use;

    // Youngest producer wins; x0 is hard-wired to zero regardless of any writer.
    function automatic logic [XLEN-1:0] fwd(input logic [REG_ADDR_W-1:0] src,
                                            input logic [XLEN-1:0]       rf_data);
        if (src == '0)
            return '0;
        else if (valid_q && rw_q && !mr_q && rd_q == src)
            return ex_fwd_data;
        else if (mem_reg_write && mem_rd == src)
            return mem_data;
        else if (wb_reg_write && wb_rd == src)
            return wb_data;
        else
            return rf_data;
    endfunction

    always_comb begin
        in1_d   = fwd(id_rs1, id_rs1_data);
        rs2_fwd = fwd(id_rs2, id_rs2_data);
        in2_d   = id_use_imm ? id_imm : rs2_fwd;
        store_d = rs2_fwd;
    end

    // An immediate-form rs2 only matters to a load if the instruction is a store needing rs2 data.
    assign load_use = valid_q && mr_q && (rd_q != '0) &&
                      ((rd_q == id_rs1) || ((rd_q == id_rs2) && (!id_use_imm || id_mem_write)));
    assign advance  = !valid_q || ex_ready;
    assign id_ready = advance && !load_use && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            in1_q   <= '0;
            in2_q   <= '0;
            store_q <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!advance) begin
            valid_q <= valid_q;
        end else if (load_use) begin
            valid_q <= 1'b0;
        end else if (id_valid) begin
            valid_q <= 1'b1;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            store_q <= store_d;
            alu_q   <= id_alu_control;
            rd_q    <= id_rd;
            rw_q    <= id_reg_write;
            mr_q    <= id_mem_read;
            mw_q    <= id_mem_write;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_in1         = in1_q;
    assign ex_in2         = in2_q;
    assign ex_store_data  = store_q;
    assign ex_alu_control = alu_q;
    assign ex_rd          = rd_q;
    assign ex_reg_write   = valid_q && rw_q;
    assign ex_mem_read    = valid_q && mr_q;
    assign ex_mem_write   = valid_q && mw_q;

`ifdef ISSUE_PERF_COUNTERS_EN
    logic [31:0] issued_q, stalls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q <= '0;
            stalls_q <= '0;
        end else begin
            if (id_valid && id_ready)
                issued_q <= issued_q + 32'd1;
            if (id_valid && !id_ready && !flush)
                stalls_q <= stalls_q + 32'd1;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected operands queued at issue, compared when EX consumes.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm;
    logic [3:0]  id_alu_control;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        flush, ex_ready;
    logic [31:0] ex_fwd_data;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_data, wb_data;
    logic        ex_valid;
    logic [31:0] ex_in1, ex_in2, ex_store_data;
    logic [3:0]  ex_alu_control;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    typedef struct {
        logic [31:0] in1, in2, st;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        rw, mr, mw;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_control(id_alu_control),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .ex_ready(ex_ready), .ex_fwd_data(ex_fwd_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2),
        .ex_store_data(ex_store_data), .ex_alu_control(ex_alu_control), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic ui, input logic [3:0] alu,
                          input logic rw, input logic mr, input logic mw);
        id_valid = 1'b1;  id_rs1 = rs1;  id_rs2 = rs2;  id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_use_imm = ui;
        id_alu_control = alu; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic push(input logic [31:0] in1, input logic [31:0] in2, input logic [31:0] st,
                        input logic [3:0] alu, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw);
        exp_t e;
        e.in1 = in1; e.in2 = in2; e.st = st; e.alu = alu; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = mw;
        sb.push_back(e);
    endtask

    task automatic idle();
        id_valid = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0; ex_fwd_data = '0;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_vld"},   32'(ex_valid), 32'd0);
        check({tag, "_in1"},   ex_in1, 32'd0);
        check({tag, "_in2"},   ex_in2, 32'd0);
        check({tag, "_st"},    ex_store_data, 32'd0);
        check({tag, "_alu"},   32'(ex_alu_control), 32'd0);
        check({tag, "_rd"},    32'(ex_rd), 32'd0);
        check({tag, "_rw"},    32'(ex_reg_write), 32'd0);
        check({tag, "_mr"},    32'(ex_mem_read), 32'd0);
        check({tag, "_mw"},    32'(ex_mem_write), 32'd0);
    endtask

    // Consumer side: an instruction retires from this stage when EX accepts it.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && ex_valid && ex_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_in1", ex_in1, e.in1);
                check("sb_in2", ex_in2, e.in2);
                check("sb_st",  ex_store_data, e.st);
                check("sb_alu", 32'(ex_alu_control), 32'(e.alu));
                check("sb_rd",  32'(ex_rd), 32'(e.rd));
                check("sb_rw",  32'(ex_reg_write), 32'(e.rw));
                check("sb_mr",  32'(ex_mem_read), 32'(e.mr));
                check("sb_mw",  32'(ex_mem_write), 32'(e.mw));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rs1_data = '0; id_rs2_data = '0;
        id_imm = '0; id_use_imm = 1'b0; id_alu_control = '0;
        mem_rd = '0; mem_data = '0; wb_rd = '0; wb_data = '0;
        idle();
        step(); step();
        @(negedge clk);
        check_empty("rst");
        step();
        reset = 1'b0;

        // Back-to-back dependency through EX forwarding
        set_id(5'd1, 5'd2, 5'd5, 32'h10, 32'h20, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        push(32'h10, 32'h20, 32'h20, 4'b0000, 5'd5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("dep_a_rdy", 32'(id_ready), 32'd1);
        step();
        set_id(5'd5, 5'd3, 5'd6, 32'hDEAD, 32'h3, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        ex_fwd_data = 32'h30;
        push(32'h30, 32'h3, 32'h3, 4'b0000, 5'd6, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("dep_b_rdy", 32'(id_ready), 32'd1);
        step();
        idle();
        step();

        // Load-use: one stall cycle, bubble, then MEM forwarding
        set_id(5'd1, 5'd0, 5'd7, 32'h100, 32'h0, 32'h4, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        push(32'h100, 32'h4, 32'h0, 4'b0000, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        set_id(5'd7, 5'd1, 5'd8, 32'h5555, 32'h7, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("lu_stall_rdy", 32'(id_ready), 32'd0);
        step();
        mem_rd = 5'd7; mem_reg_write = 1'b1; mem_data = 32'h11223344;
        push(32'h11223344, 32'h7, 32'h7, 4'b0000, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("lu_bubble_vld", 32'(ex_valid), 32'd0);
        check("lu_bubble_rw",  32'(ex_reg_write), 32'd0);
        check("lu_bubble_mr",  32'(ex_mem_read), 32'd0);
        check("lu_after_rdy",  32'(id_ready), 32'd1);
        step();
        idle();
        step();

        // x0 never forwarded
        wb_rd = 5'd0; wb_reg_write = 1'b1; wb_data = 32'hFFFFFFFF;
        set_id(5'd0, 5'd2, 5'd11, 32'h1234, 32'h9, 32'h0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
        push(32'h0, 32'h9, 32'h9, 4'b0001, 5'd11, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        step();

        // MEM beats WB on the same register; then WB-only and immediate path
        mem_rd = 5'd4; mem_reg_write = 1'b1; mem_data = 32'hA;
        wb_rd = 5'd4; wb_reg_write = 1'b1; wb_data = 32'hB;
        set_id(5'd3, 5'd4, 5'd12, 32'h33, 32'hC, 32'h0, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0);
        push(32'h33, 32'hA, 32'hA, 4'b1001, 5'd12, 1'b1, 1'b0, 1'b0);
        step();
        wb_rd = 5'd9; wb_data = 32'hB9;
        set_id(5'd9, 5'd4, 5'd13, 32'h99, 32'hC, 32'hFFFFFFF0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b1);
        push(32'hB9, 32'hFFFFFFF0, 32'hA, 4'b0011, 5'd13, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        step();

        // Backpressure for three cycles, then flush discards the held instruction
        set_id(5'd1, 5'd2, 5'd10, 32'h55, 32'h66, 32'h0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1);
        step();
        ex_ready = 1'b0;
        set_id(5'd2, 5'd3, 5'd14, 32'h77, 32'h88, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_vld", 32'(ex_valid), 32'd1);
            check("bp_in1", ex_in1, 32'h55);
            check("bp_in2", ex_in2, 32'h66);
            check("bp_st",  ex_store_data, 32'h66);
            check("bp_rd",  32'(ex_rd), 32'd10);
            check("bp_rdy", 32'(id_ready), 32'd0);
            step();
        end
        flush = 1'b1;
        @(negedge clk);
        check("fl_rdy", 32'(id_ready), 32'd0);
        step();
        flush = 1'b0;
        idle();
        ex_ready = 1'b1;
        @(negedge clk);
        check("fl_vld", 32'(ex_valid), 32'd0);
        check("fl_rw",  32'(ex_reg_write), 32'd0);
        check("fl_mw",  32'(ex_mem_write), 32'd0);
        step();

        // Reset arriving while a load-use stall is pending
        ex_ready = 1'b0;
        set_id(5'd1, 5'd0, 5'd7, 32'h200, 32'h0, 32'h8, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        step();
        ex_ready = 1'b1;
        reset = 1'b1;
        set_id(5'd7, 5'd1, 5'd8, 32'h0, 32'h1, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("rs_stall_rdy", 32'(id_ready), 32'd0);
        step();
        reset = 1'b0;
        idle();
        @(negedge clk);
        check_empty("rs_mid");
        check("rs_after_rdy", 32'(id_ready), 32'd1);
        step();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Accepts decoded instructions from ID over a valid/ready handshake and resolves the two source operands through a forwarding network (EX, MEM, WB).
- Detects load-use hazards and inserts bubbles.
- Registers the final in1/in2/alu_control presented to the ALU.
- Store data (forwarded rs2) is carried alongside for the MEM stage.

Parameters:
- XLEN, 32, operand/result width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID presents an instruction.
- id_ready  output  1  stage accepts the ID instruction this cycle.
- id_rs1, id_rs2  input  REG_ADDR_W  source register indices.
- id_rd  input  REG_ADDR_W  destination index.
- id_rs1_data, id_rs2_data  input  XLEN  register-file read data.
- id_imm  input  XLEN  sign-extended immediate.
- id_use_imm  input  1  in2 takes id_imm instead of rs2.
- id_alu_control  input  4  ALU opcode (0000..1010).
- id_reg_write, id_mem_read, id_mem_write  input  1  control bits.
- flush  input  1  branch/exception squash.
- ex_ready  input  1  ALU/EX consumer accepts the held instruction.
- ex_fwd_data  input  XLEN  ALU result of the instruction currently held here.
- mem_rd  input  REG_ADDR_W  MEM-stage destination.
- mem_reg_write  input  1  MEM-stage write enable.
- mem_data  input  XLEN  MEM-stage result (load data already merged).
- wb_rd  input  REG_ADDR_W  WB-stage destination.
- wb_reg_write  input  1  WB-stage write enable.
- wb_data  input  XLEN  WB-stage write data.
- ex_valid  output  1  held instruction valid.
- ex_in1, ex_in2  output  XLEN  ALU operands.
- ex_store_data  output  XLEN  forwarded rs2 value.
- ex_alu_control  output  4  ALU opcode.
- ex_rd  output  REG_ADDR_W  destination.
- ex_reg_write, ex_mem_read, ex_mem_write  output  1  control bits.

Behaviour:
- Reset (synchronous, active-high): all ex_* outputs 0.
- Latency: one cycle from ID acceptance to ex_valid.
- Forwarding per source s in {rs1, rs2}; first match wins:
  - EX: ex_valid && ex_reg_write && !ex_mem_read && ex_rd==s -> ex_fwd_data.
  - MEM: mem_reg_write && mem_rd==s -> mem_data.
  - WB: wb_reg_write && wb_rd==s -> wb_data.
  - Otherwise register-file data.
  - s==0 is never forwarded and always yields 0.
- Operand selection:
  - in1 = fwd(rs1).
  - in2 = id_use_imm ? id_imm : fwd(rs2).
  - store_data = fwd(rs2) always.
  - Opcodes 1001/1010 use rs2 as the mask; decode must hold id_use_imm=0 for them, and the stage does not check this.
- Load-use hazard: load_use = ex_valid && ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || (ex_rd==id_rs2 && (!id_use_imm || id_mem_write))).
- Handshake:
  - advance = !ex_valid || ex_ready.
  - id_ready = advance && !load_use && !flush.
  - id_ready is a combinational output.
- Register update priority, highest first:
  1. reset.
  2. flush: ex_valid<=0, other fields don't-care, ID instruction not accepted.
  3. !advance: hold all outputs unchanged.
  4. load_use: bubble, ex_valid<=0 (clears the load's EX slot; the next cycle forwards from MEM).
  5. id_valid: capture, ex_valid<=1.
  6. Otherwise ex_valid<=0.
- Control bits are gated with ex_valid. A bubble drives ex_reg_write, ex_mem_read and ex_mem_write to 0.
- Flush during hold: the held instruction is discarded even if ex_ready=0.
- Reset mid-stall: the stage returns to empty, and id_ready=1 the following cycle.
- Simultaneous MEM and WB writes to the same register: MEM wins (younger).
- No arithmetic is performed; widths pass through unchanged.

Optional Feature:
- Macro: ISSUE_PERF_COUNTERS_EN.
- When defined, adds outputs perf_issued[31:0] and perf_stalls[31:0].
  - perf_issued increments on each capture (id_valid && id_ready).
  - perf_stalls increments each cycle with id_valid && !id_ready && !flush.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Back-to-back dependency: ADD x5=x1+x2, then ADD x6=x5+x3 with ex_fwd_data=0x00000030 and regfile x5=0xDEAD -> second ex_in1=0x00000030, no stall.
- Load-use: LW x7 held with ex_mem_read=1, next ADD x8=x7+x1 -> id_ready=0 for 1 cycle and a bubble (ex_valid=0). Next cycle mem_rd=7, mem_data=0x11223344 -> ex_in1=0x11223344.
- x0 guard: rs1=0 with wb_rd=0, wb_reg_write=1, wb_data=0xFFFFFFFF -> ex_in1=0.
- Priority: rs2=4, mem_rd=4 (data 0xA), wb_rd=4 (data 0xB), opcode 1001 -> ex_in2=0xA.
- Backpressure then flush: ex_valid=1, ex_ready=0 for 3 cycles -> outputs stable and id_ready=0; flush asserted -> ex_valid=0 the next cycle.
- Reset during load-use stall -> all ex_* outputs 0, and id_ready=1 the cycle after reset deasserts.
